mode_world_clock_table: RTL and testbench

- Parametrised world-time display mode for the term-project clock. It is the next generation of the fixed 12-city world-time mode.
- City names and UTC offsets are held in a run-time writable table. Offsets are in 15-minute steps, so half- and quarter-hour zones are supported.
- Shows a day-rollover indicator and supports 12 h or 24 h display.
- Drives the shared character-LCD bus (RW/RS/DATA) while MODE equals MODE_ID; otherwise the bus is held idle for the mode mux.

---
 rtl/mode_world_clock_table.sv | 232 +++++++++++++++++++++++
 tb/tb_mode_world_clock_table.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mode_world_clock_table.sv
// mode_world_clock_table
// World-time display mode with a run-time writable city table.
// Each entry holds a three-letter name and a signed UTC offset in quarter
// hours. While MODE equals MODE_ID the block streams a 34-slot frame onto the
// shared character-LCD bus; otherwise the bus is held idle (RW=1, RS=1, 8'h02).
//
// Ports:
//   CLK, RESET      clock, asynchronous active-low reset
//   NUM_SYNC[3:2]   one-cycle key pulses: [2] next city, [3] previous city
//   MODE            global mode; this block is active when MODE == MODE_ID
//   MERIDIEM/HOUR/MIN/SEC  home time (12 h form)
//   FMT24           1 = 24 h display, 0 = 12 h display
//   CFG_WE/CFG_IDX/CFG_NAME/CFG_OFF  table write port
//   CFG_ERR         one-cycle pulse when a write is rejected
//   CITY_IDX        currently selected entry
//   RW_OUTPUT/RS_OUTPUT/DATA_OUTPUT  LCD bus
module mode_world_clock_table #(
    parameter int          N_CITY        = 12,
    parameter int          IDX_W         = 4,
    parameter int          HOME_OFFSET_Q = 36,
    parameter int          BLINK_HALF    = 500,
    parameter logic [3:0]  MODE_ID       = 4'b0111
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:2]        NUM_SYNC,
    input  logic [3:0]        MODE,
    input  logic              MERIDIEM,
    input  logic [6:0]        HOUR,
    input  logic [6:0]        MIN,
    input  logic [6:0]        SEC,
    input  logic              FMT24,
    input  logic              CFG_WE,
    input  logic [IDX_W-1:0]  CFG_IDX,
    input  logic [23:0]       CFG_NAME,
    input  logic signed [7:0] CFG_OFF,
    output logic              CFG_ERR,
    output logic [IDX_W-1:0]  CITY_IDX,
    output logic              RW_OUTPUT,
    output logic              RS_OUTPUT,
    output logic [7:0]        DATA_OUTPUT
);
    localparam int BW = $clog2(2 * BLINK_HALF);

    // City table: registers rather than RAM, since every entry must come out
    // of reset as "GMT" with offset 0.
    logic [23:0]       name_mem [N_CITY];
    logic signed [7:0] off_mem  [N_CITY];
    logic [N_CITY-1:0] wr_sel;
    logic              cfg_ok;

    logic [IDX_W-1:0]  city_idx_reg;
    logic              cfg_err_reg;
    logic              in_mode;

    // World-time snapshot, one cycle behind inputs and table.
    logic [4:0]  world_hour_reg, world_hour_next;
    logic [5:0]  world_min_reg,  world_min_next;
    logic [6:0]  world_sec_reg;
    logic [1:0]  day_reg,        day_next;        // 01 = +1, 10 = -1
    logic [23:0] name_reg;
    logic        off_neg_reg,    off_neg_next;
    logic [3:0]  off_hh_reg,     off_hh_next;
    logic [5:0]  off_mm_reg,     off_mm_next;
    logic        fmt24_reg;

    logic [5:0]    slot_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          rw_reg, rs_reg, rs_next;
    logic [7:0]    data_reg, data_next;

    assign in_mode     = (MODE == MODE_ID);
    assign CFG_ERR     = cfg_err_reg;
    assign CITY_IDX    = city_idx_reg;
    assign RW_OUTPUT   = rw_reg;
    assign RS_OUTPUT   = rs_reg;
    assign DATA_OUTPUT = data_reg;

    assign cfg_ok = ({1'b0, CFG_IDX} < (IDX_W + 1)'(N_CITY)) &&
                    (CFG_OFF >= -8'sd48) && (CFG_OFF <= 8'sd56);

    genvar gi;
    generate
        for (gi = 0; gi < N_CITY; gi++) begin : g_wr_sel
            assign wr_sel[gi] = CFG_WE && cfg_ok && (CFG_IDX == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < N_CITY; i++) begin
                name_mem[i] <= 24'h474D54;   // "GMT"
                off_mem[i]  <= '0;
            end
            cfg_err_reg <= 1'b0;
        end else begin
            for (int i = 0; i < N_CITY; i++) begin
                if (wr_sel[i]) begin
                    name_mem[i] <= CFG_NAME;
                    off_mem[i]  <= CFG_OFF;
                end
            end
            cfg_err_reg <= CFG_WE && !cfg_ok;
        end
    end

    // City selection; simultaneous next+previous cancels out.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            city_idx_reg <= '0;
        end else if (in_mode) begin
            if (NUM_SYNC == 2'b01)
                city_idx_reg <= (city_idx_reg == IDX_W'(N_CITY - 1)) ? '0 : city_idx_reg + 1'b1;
            else if (NUM_SYNC == 2'b10)
                city_idx_reg <= (city_idx_reg == '0) ? IDX_W'(N_CITY - 1) : city_idx_reg - 1'b1;
        end
    end

    // Time arithmetic in minutes of the day, wrapped into 0..1439.
    always_comb begin
        int t;
        int a;
        logic signed [7:0] sel_off;
        sel_off = off_mem[city_idx_reg];
        t = (int'(HOUR) + (MERIDIEM ? 12 : 0)) * 60 + int'(MIN)
            - HOME_OFFSET_Q * 15 + int'(sel_off) * 15;
        day_next = 2'b00;
        if (t < 0) begin
            t        = t + 1440;
            day_next = 2'b10;
        end else if (t >= 1440) begin
            t        = t - 1440;
            day_next = 2'b01;
        end
        world_hour_next = 5'(t / 60);
        world_min_next  = 6'(t % 60);
        a               = (sel_off < 0) ? -int'(sel_off) : int'(sel_off);
        off_neg_next    = (sel_off < 0);
        off_hh_next     = 4'(a / 4);
        off_mm_next     = 6'((a % 4) * 15);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            world_hour_reg <= '0;
            world_min_reg  <= '0;
            world_sec_reg  <= '0;
            day_reg        <= '0;
            name_reg       <= '0;
            off_neg_reg    <= 1'b0;
            off_hh_reg     <= '0;
            off_mm_reg     <= '0;
            fmt24_reg      <= 1'b0;
        end else begin
            world_hour_reg <= world_hour_next;
            world_min_reg  <= world_min_next;
            world_sec_reg  <= SEC;
            day_reg        <= day_next;
            name_reg       <= name_mem[city_idx_reg];
            off_neg_reg    <= off_neg_next;
            off_hh_reg     <= off_hh_next;
            off_mm_reg     <= off_mm_next;
            fmt24_reg      <= FMT24;
        end
    end

    function automatic logic [7:0] asc(input int v);
        return 8'(32'h30 + v);
    endfunction

    // Character generator for the current slot.
    always_comb begin
        int hr;
        logic [7:0] colon;
        rs_next   = 1'b1;
        data_next = 8'h20;
        hr        = fmt24_reg ? int'(world_hour_reg) : int'(world_hour_reg) % 12;
        colon     = (blink_cnt_reg < BW'(BLINK_HALF)) ? 8'h3A : 8'h20;
        case (slot_reg)
            6'd0:  begin rs_next = 1'b0; data_next = 8'h80; end
            6'd1:  data_next = 8'h11;
            6'd3:  data_next = name_reg[23:16];
            6'd4:  data_next = name_reg[15:8];
            6'd5:  data_next = name_reg[7:0];
            6'd7:  data_next = off_neg_reg ? 8'h2D : 8'h2B;
            6'd8:  data_next = asc(int'(off_hh_reg) / 10);
            6'd9:  data_next = asc(int'(off_hh_reg) % 10);
            6'd10: data_next = 8'h3A;                     // static colon
            6'd11: data_next = asc(int'(off_mm_reg) / 10);
            6'd12: data_next = asc(int'(off_mm_reg) % 10);
            6'd16: data_next = 8'h10;
            6'd17: begin rs_next = 1'b0; data_next = 8'hC0; end
            6'd18: data_next = 8'h44;                     // 'D'
            6'd19: data_next = day_reg[0] ? 8'h2B : (day_reg[1] ? 8'h2D : 8'h20);
            6'd20: data_next = (day_reg != 2'b00) ? 8'h31 : 8'h30;
            6'd22: data_next = fmt24_reg ? 8'h20 : ((world_hour_reg < 5'd12) ? 8'h41 : 8'h50);
            6'd23: data_next = fmt24_reg ? 8'h20 : 8'h4D;
            6'd25: data_next = asc(hr / 10);
            6'd26: data_next = asc(hr % 10);
            6'd27: data_next = colon;
            6'd28: data_next = asc(int'(world_min_reg) / 10);
            6'd29: data_next = asc(int'(world_min_reg) % 10);
            6'd30: data_next = colon;
            6'd31: data_next = asc(int'(world_sec_reg) / 10);
            6'd32: data_next = asc(int'(world_sec_reg) % 10);
            default: ;
        endcase
    end

    // Frame sequencer, blink counter and registered LCD bus.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            slot_reg      <= '0;
            blink_cnt_reg <= '0;
            rw_reg        <= 1'b1;
            rs_reg        <= 1'b1;
            data_reg      <= 8'h02;
        end else if (in_mode) begin
            slot_reg      <= (slot_reg == 6'd33) ? 6'd0 : slot_reg + 6'd1;
            blink_cnt_reg <= (blink_cnt_reg == BW'(2 * BLINK_HALF - 1)) ? '0 : blink_cnt_reg + 1'b1;
            rw_reg        <= 1'b0;
            rs_reg        <= rs_next;
            data_reg      <= data_next;
        end else begin
            slot_reg      <= '0;
            blink_cnt_reg <= '0;
            rw_reg        <= 1'b1;
            rs_reg        <= 1'b1;
            data_reg      <= 8'h02;
        end
    end
endmodule

// File: tb/tb_mode_world_clock_table.sv
// Directed testbench for mode_world_clock_table: frame contents, time
// arithmetic, table writes, city selection, blink and mode exit.
module tb_mode_world_clock_table;
    localparam logic [3:0] MID = 4'b0111;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic [3:2]        NUM_SYNC = 2'b00;
    logic [3:0]        MODE = 4'd0;
    logic              MERIDIEM = 1'b0;
    logic [6:0]        HOUR = '0, MIN = '0, SEC = '0;
    logic              FMT24 = 1'b0;
    logic              CFG_WE = 1'b0;
    logic [3:0]        CFG_IDX = '0;
    logic [23:0]       CFG_NAME = '0;
    logic signed [7:0] CFG_OFF = '0;
    logic              CFG_ERR;
    logic [3:0]        CITY_IDX;
    logic              RW_OUTPUT, RS_OUTPUT;
    logic [7:0]        DATA_OUTPUT;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] cap_d  [102];
    logic       cap_rs [102];
    logic       cap_rw [102];

    mode_world_clock_table #(.BLINK_HALF(40)) dut (
        .CLK(CLK), .RESET(RESET), .NUM_SYNC(NUM_SYNC), .MODE(MODE),
        .MERIDIEM(MERIDIEM), .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .FMT24(FMT24),
        .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX), .CFG_NAME(CFG_NAME), .CFG_OFF(CFG_OFF),
        .CFG_ERR(CFG_ERR), .CITY_IDX(CITY_IDX),
        .RW_OUTPUT(RW_OUTPUT), .RS_OUTPUT(RS_OUTPUT), .DATA_OUTPUT(DATA_OUTPUT)
    );

    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Restart the frame from slot 0 and capture nf frames.
    task automatic grab_frames(input int nf);
        @(negedge CLK) MODE = 4'd0;
        @(negedge CLK) MODE = MID;
        for (int i = 0; i < nf * 34; i++) begin
            @(posedge CLK);
            #1;
            cap_d[i]  = DATA_OUTPUT;
            cap_rs[i] = RS_OUTPUT;
            cap_rw[i] = RW_OUTPUT;
        end
    endtask

    function automatic logic [127:0] line_at(input int base);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[119:0], cap_d[base + i]};
        return r;
    endfunction

    function automatic logic [127:0] rs_rw_bits();
        logic [127:0] r = '0;
        for (int i = 0; i < 34; i++) r = {r[125:0], cap_rs[i], cap_rw[i]};
        return r;
    endfunction

    task automatic check_frame(input string tag, input logic [127:0] e1, input logic [127:0] e2);
        logic [127:0] rs_exp;
        rs_exp = '0;
        for (int i = 0; i < 34; i++) rs_exp = {rs_exp[125:0], (i != 0 && i != 17), 1'b0};
        grab_frames(1);
        check_vec({tag, "_slot0"},  {119'd0, cap_rs[0], cap_d[0]},   128'h080);
        check_vec({tag, "_line1"},  line_at(1),  e1);
        check_vec({tag, "_slot17"}, {119'd0, cap_rs[17], cap_d[17]}, 128'h0C0);
        check_vec({tag, "_line2"},  line_at(18), e2);
        check_vec({tag, "_rs_rw"},  rs_rw_bits(), rs_exp);
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [23:0] nm,
                             input logic signed [7:0] off, input logic exp_err);
        @(negedge CLK);
        CFG_WE = 1'b1; CFG_IDX = idx; CFG_NAME = nm; CFG_OFF = off;
        @(posedge CLK);
        #1 check_vec("cfg_err", {127'd0, CFG_ERR}, {127'd0, exp_err});
        @(negedge CLK) CFG_WE = 1'b0;
        @(posedge CLK);
        #1 check_vec("cfg_err_clear", {127'd0, CFG_ERR}, 128'd0);
    endtask

    task automatic key(input logic [1:0] v, input logic [3:0] exp_idx);
        @(negedge CLK);
        MODE = MID; NUM_SYNC = v;
        @(posedge CLK);
        #1 check_vec("city_idx", {124'd0, CITY_IDX}, {124'd0, exp_idx});
        @(negedge CLK) NUM_SYNC = 2'b00;
    endtask

    task automatic set_time(input logic m, input logic [6:0] h, input logic [6:0] mn, input logic [6:0] s);
        MERIDIEM = m; HOUR = h; MIN = mn; SEC = s;
    endtask

    initial begin
        // Reset state while RESET is held low.
        repeat (3) @(posedge CLK);
        #1;
        check_vec("reset_bus", {118'd0, RW_OUTPUT, RS_OUTPUT, DATA_OUTPUT}, 128'h302);
        check_vec("reset_idx", {124'd0, CITY_IDX}, 128'd0);
        check_vec("reset_err", {127'd0, CFG_ERR}, 128'd0);
        @(negedge CLK) RESET = 1'b1;

        // Default table, home PM 10:30:15 -> GMT 13:30.
        set_time(1'b1, 7'd10, 7'd30, 7'd15);
        check_frame("gmt", {8'h11, " GMT +00:00   ", 8'h10}, "D 0 PM 01:30:15 ");

        // Blink: colon at slot 27 sees blink counts 27, 61, 15 in three frames.
        grab_frames(3);
        check_vec("blink_f0", {120'd0, cap_d[27]},  128'h3A);
        check_vec("blink_f1", {120'd0, cap_d[61]},  128'h20);
        check_vec("blink_f2", {120'd0, cap_d[95]},  128'h3A);

        // NYC, -5:00.
        cfg_write(4'd1, "NYC", -8'sd20, 1'b0);
        key(2'b01, 4'd1);
        check_frame("nyc", {8'h11, " NYC -05:00   ", 8'h10}, "D 0 AM 08:30:15 ");

        // DEL, +5:30, in 12 h and 24 h.
        cfg_write(4'd2, "DEL", 8'sd22, 1'b0);
        key(2'b01, 4'd2);
        check_frame("del12", {8'h11, " DEL +05:30   ", 8'h10}, "D 0 PM 07:00:15 ");
        FMT24 = 1'b1;
        check_frame("del24", {8'h11, " DEL +05:30   ", 8'h10}, "D 0    19:00:15 ");
        FMT24 = 1'b0;

        // Previous-day rollover: NYC, home AM 01:00.
        key(2'b10, 4'd1);
        set_time(1'b0, 7'd1, 7'd0, 7'd0);
        check_frame("nyc_dm1", {8'h11, " NYC -05:00   ", 8'h10}, "D-1 AM 11:00:00 ");

        // Next-day rollover: max offset +14:00, home PM 11:00.
        cfg_write(4'd3, "LNX", 8'sd56, 1'b0);
        key(2'b01, 4'd2);
        key(2'b01, 4'd3);
        set_time(1'b1, 7'd11, 7'd0, 7'd0);
        check_frame("lnx_dp1", {8'h11, " LNX +14:00   ", 8'h10}, "D+1 AM 04:00:00 ");

        // Rejected writes leave the table untouched; -48 is accepted.
        cfg_write(4'd3, "BAD", 8'sd60, 1'b1);
        cfg_write(4'd12, "BAD", 8'sd0, 1'b1);
        cfg_write(4'd4, "BAD", -8'sd49, 1'b1);
        check_frame("lnx_kept", {8'h11, " LNX +14:00   ", 8'h10}, "D+1 AM 04:00:00 ");
        cfg_write(4'd4, "MIN", -8'sd48, 1'b0);
        key(2'b01, 4'd4);
        check_frame("min", {8'h11, " MIN -12:00   ", 8'h10}, "D 0 AM 02:00:00 ");

        // Index wrap in both directions, both-keys and out-of-mode ignored.
        key(2'b10, 4'd3);
        key(2'b10, 4'd2);
        key(2'b10, 4'd1);
        key(2'b10, 4'd0);
        key(2'b10, 4'd11);
        key(2'b01, 4'd0);
        key(2'b11, 4'd0);
        @(negedge CLK);
        MODE = 4'd0; NUM_SYNC = 2'b01;
        @(posedge CLK);
        #1 check_vec("idx_out_of_mode", {124'd0, CITY_IDX}, 128'd0);
        @(negedge CLK) NUM_SYNC = 2'b00;

        // Leave mid-frame after slot 20 (GMT 14:00 -> "D 0 PM 02:00:00").
        @(negedge CLK) MODE = 4'd0;
        @(negedge CLK) MODE = MID;
        repeat (21) @(posedge CLK);
        #1 check_vec("slot20", {118'd0, RW_OUTPUT, RS_OUTPUT, DATA_OUTPUT}, {118'd0, 2'b01, 8'h30});
        @(negedge CLK) MODE = 4'd0;
        @(posedge CLK);
        #1 check_vec("exit_idle", {118'd0, RW_OUTPUT, RS_OUTPUT, DATA_OUTPUT}, 128'h302);
        @(negedge CLK) MODE = MID;
        @(posedge CLK);
        #1 check_vec("reenter_slot0", {118'd0, RW_OUTPUT, RS_OUTPUT, DATA_OUTPUT}, 128'h080);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
